p_cacheline_adaptor: RTL and testbench
======================================

Name: p_cacheline_adaptor

Overview:
- Sits directly downstream of the pipelined data-cache controller's physical-memory port.
- Converts one 256-bit cache-line read or write-back into a 4-beat, 64-bit burst transaction on the burst memory interface.
- Returns a single-cycle line response to the cache when the burst completes.
- Holds the line and the aligned address internally, so the cache may change its datapath muxes while the burst is in flight.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, burst beat width in bits.
- BEATS, LINE_W/BEAT_W (4), beats per line; derived, not overridable.
- ADDR_W, 32, physical address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- line_address_i  in  ADDR_W  byte address from the cache (any offset)
- line_read_i  in  1  cache requests a line fill; held until line_resp_o
- line_write_i  in  1  cache requests a line write-back; held until line_resp_o
- line_wdata_i  in  LINE_W  line to write back; sampled at request acceptance
- line_rdata_o  out  LINE_W  assembled fill line; valid while line_resp_o=1
- line_resp_o  out  1  one-cycle completion pulse
- burst_address_o  out  ADDR_W  32-byte-aligned address (bits [4:0]=0)
- burst_read_o  out  1  burst read request
- burst_write_o  out  1  burst write request
- burst_wdata_o  out  BEAT_W  current write beat
- burst_rdata_i  in  BEAT_W  read beat data; valid when burst_resp_i=1
- burst_resp_i  in  1  per-beat acknowledge from memory

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the beat counter is 0.
- Reset has priority over every event and aborts an in-flight burst with no response.
- States:
  - IDLE: requests are sampled only here. The controller latches {address[ADDR_W-1:5], 5'b0}, and latches line_wdata_i for a write.
    - line_write_i=1 -> WRITE.
    - Else line_read_i=1 -> READ.
    - If both are asserted, write wins; the read is serviced as a separate later request.
  - READ: burst_read_o=1 and burst_address_o is the latched address.
    - Each cycle with burst_resp_i=1 stores burst_rdata_i into line bits [64k+63:64k], where k is the beat counter, then increments k.
    - When beat k=3 is accepted -> DONE.
  - WRITE: burst_write_o=1 and burst_wdata_o = latched line [64k+63:64k].
    - k advances on burst_resp_i. When beat k=3 is accepted -> DONE.
  - DONE: line_resp_o=1 for exactly one cycle and line_rdata_o holds the assembled line; next state is IDLE.
- Output stability:
  - burst_read_o / burst_write_o stay continuously high from the first cycle of READ/WRITE until the cycle the 4th beat is accepted. They are low in DONE.
  - burst_address_o holds constant for the whole burst.
- Beat timing:
  - Memory may insert any number of wait cycles between beats.
  - Back-to-back burst_resp_i on consecutive cycles is legal and must be fully absorbed.
- burst_resp_i outside READ/WRITE is ignored.
- The beat counter is 2 bits and wraps 3->0 on the final beat; it is also cleared on entry to IDLE.
- Latency:
  - Request accepted at cycle T; burst request is visible at T+1.
  - With zero-wait memory (4 consecutive resp), line_resp_o fires at T+5.
- A request still asserted in the cycle after DONE is treated as a new request. The cache must drop its request on seeing line_resp_o.
- line_rdata_o retains its last value after DONE; it is 0 only after reset.

Decomposition:
- Shared package (alongside rv32i_types/cache_mux_types), new `burst_types`:
  - constants LINE_W, BEAT_W, BEATS, OFFSET_BITS=5;
  - enum adaptor_state_t {IDLE, READ, WRITE, DONE}.
- One sub-module is natural: `line_shift_reg`, a 256-bit register with an indexed 64-bit beat load and an indexed beat select.
- FSM and beat counter stay in the top module.

Test Plan:
- Zero-wait read: line_read_i=1, address 0x0000_1234 -> burst_address_o=0x0000_1220; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> line_rdata_o={0x44..,0x33..,0x22..,0x11..}; line_resp_o high exactly at T+5.
- Write with waits: line_write_i=1, line_wdata_i = beats {D,C,B,A}; memory gives 2 wait cycles before each resp -> burst_wdata_o shows A,B,C,D in order; burst_write_o stays high 12 cycles; one line_resp_o pulse.
- Simultaneous read+write in IDLE -> WRITE burst first, line_resp_o, then with read still high a READ burst follows; burst_read_o and burst_write_o are never both 1.
- Reset mid-burst: assert rst after beat 1 of a read -> next cycle all outputs 0, no line_resp_o; a subsequent read completes normally with k starting at 0.
- Stray burst_resp_i=1 in IDLE/DONE -> no state change, counter stays 0.
- line_wdata_i changed to garbage after acceptance -> written beats still match the originally latched line.

Source files
------------

// File: rtl/p_cacheline_adaptor_pkg.sv
// Shared burst-side types and constants for the cache-line to burst adaptor.
package burst_types;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = 5;
  localparam int BEAT_IDX_W  = $clog2(BEATS);
  localparam int BEAT_SH     = $clog2(BEAT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  // Beat index that follows k, wrapping at the end of the line.
  function automatic logic [BEAT_IDX_W-1:0] next_beat(input logic [BEAT_IDX_W-1:0] k);
    return k + BEAT_IDX_W'(1);
  endfunction

endpackage

// File: rtl/p_cacheline_adaptor_line_shift_reg.sv
// Line-wide holding register: whole-line load, indexed beat load, indexed beat select.
module line_shift_reg
  import burst_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_line,
  input  logic [LINE_W-1:0]     line_in,
  input  logic                  load_beat,
  input  logic [BEAT_IDX_W-1:0] beat_idx,
  input  logic [BEAT_W-1:0]     beat_in,
  input  logic [BEAT_IDX_W-1:0] sel_idx,
  output logic [BEAT_W-1:0]     beat_out,
  output logic [LINE_W-1:0]     line_d
);

  logic [LINE_W-1:0]               line_r;
  logic [BEAT_IDX_W+BEAT_SH-1:0]   load_base_s;
  logic [BEAT_IDX_W+BEAT_SH-1:0]   sel_base_s;

  assign load_base_s = {beat_idx, {BEAT_SH{1'b0}}};
  assign sel_base_s  = {sel_idx, {BEAT_SH{1'b0}}};

  // Next line contents; exposed so the final read beat can be captured in the same cycle.
  always_comb begin
    line_d = line_r;
    if (load_line) begin
      line_d = line_in;
    end else if (load_beat) begin
      line_d[load_base_s +: BEAT_W] = beat_in;
    end else begin
      line_d = line_r;
    end
  end

  // Line storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r <= {LINE_W{1'b0}};
    end else begin
      line_r <= line_d;
    end
  end

  assign beat_out = line_r[sel_base_s +: BEAT_W];

endmodule

// File: rtl/p_cacheline_adaptor.sv
// Converts a 256-bit cache-line read/write-back into a 4-beat 64-bit burst and
// returns a one-cycle line response when the burst completes.
module p_cacheline_adaptor
  import burst_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] line_address_i,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic [ADDR_W-1:0] burst_address_o,
  output logic              burst_read_o,
  output logic              burst_write_o,
  output logic [BEAT_W-1:0] burst_wdata_o,
  input  logic [BEAT_W-1:0] burst_rdata_i,
  input  logic              burst_resp_i
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((32'd1 << OFFSET_BITS) - 32'd1);

  adaptor_state_t        state_r, state_d;
  logic [BEAT_IDX_W-1:0] beat_cnt_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [LINE_W-1:0]     line_rdata_r;
  logic                  line_resp_r;
  logic                  burst_read_r;
  logic                  burst_write_r;
  logic [BEAT_W-1:0]     burst_wdata_r, burst_wdata_d;

  logic                  in_burst_s, beat_ack_s, last_beat_s;
  logic                  load_line_s, load_beat_s, accept_s;
  logic [BEAT_W-1:0]     next_wbeat_s;
  logic [LINE_W-1:0]     line_next_s;

  assign in_burst_s  = (state_r == READ) || (state_r == WRITE);
  assign beat_ack_s  = in_burst_s && burst_resp_i;
  assign last_beat_s = beat_ack_s && (beat_cnt_r == BEAT_IDX_W'(BEATS - 1));
  assign accept_s    = (state_r == IDLE) && (line_read_i || line_write_i);
  assign load_line_s = (state_r == IDLE) && line_write_i;
  assign load_beat_s = (state_r == READ) && burst_resp_i;

  line_shift_reg u_line (
    .clk       (clk),
    .rst       (rst),
    .load_line (load_line_s),
    .line_in   (line_wdata_i),
    .load_beat (load_beat_s),
    .beat_idx  (beat_cnt_r),
    .beat_in   (burst_rdata_i),
    .sel_idx   (next_beat(beat_cnt_r)),
    .beat_out  (next_wbeat_s),
    .line_d    (line_next_s)
  );

  // Next-state logic; write wins when both requests arrive together.
  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: begin
        if (line_write_i) begin
          state_d = WRITE;
        end else if (line_read_i) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ, WRITE: begin
        if (last_beat_s) begin
          state_d = DONE;
        end else begin
          state_d = state_r;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write beat presented next cycle: first beat straight from the request, later beats from the held line.
  always_comb begin
    burst_wdata_d = {BEAT_W{1'b0}};
    if (state_d != WRITE) begin
      burst_wdata_d = {BEAT_W{1'b0}};
    end else if (state_r == IDLE) begin
      burst_wdata_d = line_wdata_i[BEAT_W-1:0];
    end else if (beat_ack_s) begin
      burst_wdata_d = next_wbeat_s;
    end else begin
      burst_wdata_d = burst_wdata_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Beat counter: advances on each accepted beat, held at zero outside a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {BEAT_IDX_W{1'b0}};
    end else if (beat_ack_s) begin
      beat_cnt_r <= next_beat(beat_cnt_r);
    end else if (!in_burst_s) begin
      beat_cnt_r <= {BEAT_IDX_W{1'b0}};
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Registered outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r        <= {ADDR_W{1'b0}};
      line_rdata_r  <= {LINE_W{1'b0}};
      line_resp_r   <= 1'b0;
      burst_read_r  <= 1'b0;
      burst_write_r <= 1'b0;
      burst_wdata_r <= {BEAT_W{1'b0}};
    end else begin
      if (accept_s) begin
        addr_r <= line_address_i & ~OFFSET_MASK;
      end
      if ((state_r == READ) && last_beat_s) begin
        line_rdata_r <= line_next_s;
      end
      line_resp_r   <= (state_d == DONE);
      burst_read_r  <= (state_d == READ);
      burst_write_r <= (state_d == WRITE);
      burst_wdata_r <= burst_wdata_d;
    end
  end

  assign line_rdata_o    = line_rdata_r;
  assign line_resp_o     = line_resp_r;
  assign burst_address_o = addr_r;
  assign burst_read_o    = burst_read_r;
  assign burst_write_o   = burst_write_r;
  assign burst_wdata_o   = burst_wdata_r;

endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Self-checking bench: transaction-level memory model drives random-wait bursts and checks every cycle.
module tb_p_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  line_address_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  burst_address_o;
  logic         burst_read_o;
  logic         burst_write_o;
  logic [63:0]  burst_wdata_o;
  logic [63:0]  burst_rdata_i;
  logic         burst_resp_i;

  int total = 0;
  int bad   = 0;

  logic [255:0] mem [logic [31:0]];
  logic [255:0] last_rline;

  p_cacheline_adaptor #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .line_address_i  (line_address_i),
    .line_read_i     (line_read_i),
    .line_write_i    (line_write_i),
    .line_wdata_i    (line_wdata_i),
    .line_rdata_o    (line_rdata_o),
    .line_resp_o     (line_resp_o),
    .burst_address_o (burst_address_o),
    .burst_read_o    (burst_read_o),
    .burst_write_o   (burst_write_o),
    .burst_wdata_o   (burst_wdata_o),
    .burst_rdata_i   (burst_rdata_i),
    .burst_resp_i    (burst_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete line transaction; memory inserts wmin..wmax wait cycles before each beat.
  task automatic run_txn(input bit wr, input bit also_rd, input bit hold_rd,
                         input logic [31:0] addr, input logic [255:0] wline,
                         input int wmin, input int wmax);
    logic [31:0]  a_al;
    logic [255:0] rline;
    logic [255:0] got;
    int n, cyc, wcnt, twait, hi_cnt;
    a_al  = addr & 32'hFFFF_FFE0;
    rline = 256'd0;
    got   = 256'd0;
    if (!wr) begin
      if (!mem.exists(a_al)) mem[a_al] = rand_line();
      rline = mem[a_al];
    end
    @(negedge clk);
    chk("idle_read", burst_read_o, 1'b0);
    chk("idle_write", burst_write_o, 1'b0);
    chk("idle_resp", line_resp_o, 1'b0);
    line_address_i = addr;
    line_write_i   = wr;
    line_read_i    = !wr || also_rd;
    line_wdata_i   = wr ? wline : rand_line();
    n = 0; cyc = 0; twait = 0; hi_cnt = 0;
    wcnt = $urandom_range(wmax, wmin);
    while (n < 4) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) line_wdata_i = rand_line();
      chk("burst_read", burst_read_o, !wr);
      chk("burst_write", burst_write_o, wr);
      chk("burst_addr", burst_address_o, a_al);
      chk("resp_early", line_resp_o, 1'b0);
      if (wr) chk("wbeat", burst_wdata_o, wline[64*n +: 64]);
      if (burst_read_o || burst_write_o) hi_cnt++;
      if (wcnt == 0) begin
        burst_resp_i  = 1'b1;
        burst_rdata_i = wr ? {$urandom(), $urandom()} : rline[64*n +: 64];
        if (wr) got[64*n +: 64] = burst_wdata_o;
        n++;
        wcnt = $urandom_range(wmax, wmin);
      end else begin
        burst_resp_i  = 1'b0;
        burst_rdata_i = {$urandom(), $urandom()};
        wcnt--;
        twait++;
      end
    end
    @(negedge clk);
    cyc++;
    chk("resp_pulse", line_resp_o, 1'b1);
    chk("done_read", burst_read_o, 1'b0);
    chk("done_write", burst_write_o, 1'b0);
    chk("latency", cyc, 5 + twait);
    chk("req_high_cycles", hi_cnt, 4 + twait);
    if (wr) begin
      mem[a_al] = got;
      chk("rdata_retained", line_rdata_o, last_rline);
    end else begin
      chk("rdata_line", line_rdata_o, rline);
      last_rline = rline;
    end
    burst_resp_i = 1'($urandom_range(1, 0));
    line_write_i = 1'b0;
    line_read_i  = hold_rd;
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    rst = 1'b1;
    line_address_i = 32'd0;
    line_read_i    = 1'b0;
    line_write_i   = 1'b0;
    line_wdata_i   = 256'd0;
    burst_rdata_i  = 64'd0;
    burst_resp_i   = 1'b0;
    last_rline     = 256'd0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", line_rdata_o, 256'd0);
    chk("rst_resp", line_resp_o, 1'b0);
    chk("rst_addr", burst_address_o, 32'd0);
    chk("rst_read", burst_read_o, 1'b0);
    chk("rst_write", burst_write_o, 1'b0);
    chk("rst_wdata", burst_wdata_o, 64'd0);
    rst = 1'b0;

    // Zero-wait read of a known line at an unaligned address.
    mem[32'h0000_1220] = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_1234, 256'd0, 0, 0);

    // Write-back with two wait cycles before every beat.
    l = rand_line();
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_2047, l, 2, 2);
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_2040, 256'd0, 0, 1);

    // Simultaneous read and write: write first, held read follows.
    l = rand_line();
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_3010, l, 0, 1);
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_3010, 256'd0, 0, 0);

    // Stray memory responses while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      burst_resp_i = 1'b1;
      chk("stray_read", burst_read_o, 1'b0);
      chk("stray_write", burst_write_o, 1'b0);
      chk("stray_resp", line_resp_o, 1'b0);
    end
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_4000, 256'd0, 0, 0);

    // Reset after two read beats aborts the burst.
    a = 32'h0000_8040;
    mem[a] = rand_line();
    @(negedge clk);
    line_address_i = a;
    line_read_i    = 1'b1;
    burst_resp_i   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      burst_resp_i  = 1'b1;
      burst_rdata_i = mem[a][64*b +: 64];
    end
    @(negedge clk);
    rst          = 1'b1;
    burst_resp_i = 1'b0;
    @(negedge clk);
    chk("abort_read", burst_read_o, 1'b0);
    chk("abort_resp", line_resp_o, 1'b0);
    chk("abort_addr", burst_address_o, 32'd0);
    chk("abort_rdata", line_rdata_o, 256'd0);
    rst         = 1'b0;
    line_read_i = 1'b0;
    last_rline  = 256'd0;
    l = rand_line();
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_9000, l, 0, 0);
    run_txn(1'b0, 1'b0, 1'b0, a, 256'd0, 0, 2);

    // Random mix of reads and writes over a small address window.
    for (int i = 0; i < 10; i++) begin
      a = 32'h0001_0000 + ($urandom_range(7, 0) << 5) + $urandom_range(31, 0);
      run_txn(1'($urandom_range(1, 0)), 1'b0, 1'b0, a, rand_line(), 0, 3);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
